// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared opcodes, default sizes and CDB snoop result type for the ALU reservation station
package alu_rs_pkg;

    localparam int RS_SIZE_DEFAULT = 8;
    localparam int ROB_ADDR_W      = 4;

    typedef enum logic [5:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_ADDI  = 6'd11,
        OP_SLTI  = 6'd12,
        OP_SLTIU = 6'd13,
        OP_XORI  = 6'd14,
        OP_ORI   = 6'd15,
        OP_ANDI  = 6'd16,
        OP_SLLI  = 6'd17,
        OP_SRLI  = 6'd18,
        OP_SRAI  = 6'd19,
        OP_ADD   = 6'd20,
        OP_SUB   = 6'd21
    } alu_op_e;

    typedef struct packed {
        logic        hit;
        logic [31:0] val;
    } cdb_hit_t;

endpackage

// File: rtl/rs_pick.sv
// rtl/rs_pick.sv - lowest-index priority encoder returning index and found flag
module rs_pick #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - reservation station for integer/branch/jump ops, CDB wakeup and single-issue ALU dispatch
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEFAULT,
    parameter int ROB_W   = ROB_ADDR_W,
    parameter int OP_W    = 6
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             iss_valid,
    input  logic [OP_W-1:0]  iss_op,
    input  logic [31:0]      iss_vj,
    input  logic [ROB_W-1:0] iss_qj,
    input  logic             iss_qj_busy,
    input  logic [31:0]      iss_vk,
    input  logic [ROB_W-1:0] iss_qk,
    input  logic             iss_qk_busy,
    input  logic [ROB_W-1:0] iss_robid,
    input  logic             alu_valid,
    input  logic [ROB_W-1:0] alu_robid,
    input  logic [31:0]      alu_result,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_robid,
    input  logic [31:0]      lsb_result,
    output logic             full,
    output logic [31:0]      ex_rs1,
    output logic [31:0]      ex_rs2,
    output logic [OP_W-1:0]  ex_op,
    output logic [ROB_W-1:0] ex_robid
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_rj;
    logic [RS_SIZE-1:0] r_rk;
    logic [OP_W-1:0]    r_op    [RS_SIZE];
    logic [31:0]        r_vj    [RS_SIZE];
    logic [31:0]        r_vk    [RS_SIZE];
    logic [ROB_W-1:0]   r_qj    [RS_SIZE];
    logic [ROB_W-1:0]   r_qk    [RS_SIZE];
    logic [ROB_W-1:0]   r_robid [RS_SIZE];

    logic [31:0]        r_ex_rs1;
    logic [31:0]        r_ex_rs2;
    logic [OP_W-1:0]    r_ex_op;
    logic [ROB_W-1:0]   r_ex_robid;

    logic [IDX_W-1:0]   w_free_idx;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_disp_idx;
    logic               w_disp_found;
    logic [RS_SIZE-1:0] w_ready;
    logic               w_issue;
    cdb_hit_t           w_j_snp [RS_SIZE];
    cdb_hit_t           w_k_snp [RS_SIZE];
    cdb_hit_t           w_iss_j;
    cdb_hit_t           w_iss_k;

    // ALU broadcast takes precedence when both buses carry the same tag.
    function automatic cdb_hit_t snoop(
        input logic [ROB_W-1:0] tag,
        input logic             a_v,
        input logic [ROB_W-1:0] a_t,
        input logic [31:0]      a_r,
        input logic             l_v,
        input logic [ROB_W-1:0] l_t,
        input logic [31:0]      l_r
    );
        cdb_hit_t res;
        res = '0;
        if (a_v && a_t == tag) begin
            res.hit = 1'b1;
            res.val = a_r;
        end else if (l_v && l_t == tag) begin
            res.hit = 1'b1;
            res.val = l_r;
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_j_snp[i] = snoop(r_qj[i], alu_valid, alu_robid, alu_result, lsb_valid, lsb_robid, lsb_result);
            w_k_snp[i] = snoop(r_qk[i], alu_valid, alu_robid, alu_result, lsb_valid, lsb_robid, lsb_result);
        end
        w_iss_j = snoop(iss_qj, alu_valid, alu_robid, alu_result, lsb_valid, lsb_robid, lsb_result);
        w_iss_k = snoop(iss_qk, alu_valid, alu_robid, alu_result, lsb_valid, lsb_robid, lsb_result);
    end

    assign w_ready = r_busy & r_rj & r_rk;

    rs_pick #(.N(RS_SIZE)) u_free_pick (
        .i_vec   (~r_busy),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    rs_pick #(.N(RS_SIZE)) u_ready_pick (
        .i_vec   (w_ready),
        .o_idx   (w_disp_idx),
        .o_found (w_disp_found)
    );

    assign full    = ~w_free_found;
    assign w_issue = iss_valid && !full && !clear_in && rdy_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy     <= '0;
            r_ex_rs1   <= '0;
            r_ex_rs2   <= '0;
            r_ex_op    <= '0;
            r_ex_robid <= '0;
        end else if (!rdy_in) begin
            r_ex_op <= '0;
        end else if (clear_in) begin
            r_busy  <= '0;
            r_ex_op <= '0;
        end else begin
            if (w_disp_found) begin
                r_ex_rs1           <= r_vj[w_disp_idx];
                r_ex_rs2           <= r_vk[w_disp_idx];
                r_ex_op            <= r_op[w_disp_idx];
                r_ex_robid         <= r_robid[w_disp_idx];
                r_busy[w_disp_idx] <= 1'b0;
            end else begin
                r_ex_op <= '0;
            end
            if (w_issue) begin
                r_busy[w_free_idx] <= 1'b1;
            end
        end
    end

    // Payload is only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && !r_rj[i] && w_j_snp[i].hit) begin
                    r_rj[i] <= 1'b1;
                    r_vj[i] <= w_j_snp[i].val;
                end
                if (r_busy[i] && !r_rk[i] && w_k_snp[i].hit) begin
                    r_rk[i] <= 1'b1;
                    r_vk[i] <= w_k_snp[i].val;
                end
            end
            if (w_issue) begin
                r_op[w_free_idx]    <= iss_op;
                r_robid[w_free_idx] <= iss_robid;
                r_qj[w_free_idx]    <= iss_qj;
                r_qk[w_free_idx]    <= iss_qk;
                r_rj[w_free_idx]    <= !iss_qj_busy || w_iss_j.hit;
                r_rk[w_free_idx]    <= !iss_qk_busy || w_iss_k.hit;
                r_vj[w_free_idx]    <= iss_qj_busy ? w_iss_j.val : iss_vj;
                r_vk[w_free_idx]    <= iss_qk_busy ? w_iss_k.val : iss_vk;
            end
        end
    end

    assign ex_rs1   = r_ex_rs1;
    assign ex_rs2   = r_ex_rs2;
    assign ex_op    = r_ex_op;
    assign ex_robid = r_ex_robid;

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - self-checking bench for alu_rs against a slot-level behavioural model
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int RS = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        iss_valid;
    logic [5:0]  iss_op;
    logic [31:0] iss_vj;
    logic [3:0]  iss_qj;
    logic        iss_qj_busy;
    logic [31:0] iss_vk;
    logic [3:0]  iss_qk;
    logic        iss_qk_busy;
    logic [3:0]  iss_robid;
    logic        alu_valid;
    logic [3:0]  alu_robid;
    logic [31:0] alu_result;
    logic        lsb_valid;
    logic [3:0]  lsb_robid;
    logic [31:0] lsb_result;
    logic        full;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [5:0]  ex_op;
    logic [3:0]  ex_robid;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rs #(.RS_SIZE(RS), .ROB_W(4), .OP_W(6)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear_in    (clear_in),
        .iss_valid   (iss_valid),
        .iss_op      (iss_op),
        .iss_vj      (iss_vj),
        .iss_qj      (iss_qj),
        .iss_qj_busy (iss_qj_busy),
        .iss_vk      (iss_vk),
        .iss_qk      (iss_qk),
        .iss_qk_busy (iss_qk_busy),
        .iss_robid   (iss_robid),
        .alu_valid   (alu_valid),
        .alu_robid   (alu_robid),
        .alu_result  (alu_result),
        .lsb_valid   (lsb_valid),
        .lsb_robid   (lsb_robid),
        .lsb_result  (lsb_result),
        .full        (full),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_op       (ex_op),
        .ex_robid    (ex_robid)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [3:0]  qj;
        logic [3:0]  qk;
        bit          rj;
        bit          rk;
        logic [3:0]  robid;
    } ent_t;

    ent_t        m [RS];
    logic [5:0]  m_op;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic [3:0]  m_robid;

    function automatic bit m_full();
        int n = 0;
        for (int i = 0; i < RS; i++) if (m[i].busy) n++;
        return n == RS;
    endfunction

    function automatic bit m_hit(input logic [3:0] tag, output logic [31:0] v);
        v = '0;
        if (alu_valid && alu_robid == tag) begin v = alu_result; return 1'b1; end
        if (lsb_valid && lsb_robid == tag) begin v = lsb_result; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
        m_op = '0; m_rs1 = '0; m_rs2 = '0; m_robid = '0;
    endtask

    task automatic model_edge();
        ent_t        nx [RS];
        int          d, f;
        logic [31:0] v;
        if (!rdy_in) begin m_op = '0; return; end
        if (clear_in) begin
            for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
            m_op = '0;
            return;
        end
        nx = m;
        d = -1; f = -1;
        for (int i = 0; i < RS; i++) begin
            if (d < 0 && m[i].busy && m[i].rj && m[i].rk) d = i;
            if (f < 0 && !m[i].busy) f = i;
        end
        for (int i = 0; i < RS; i++) begin
            if (m[i].busy && !m[i].rj && m_hit(m[i].qj, v)) begin nx[i].rj = 1'b1; nx[i].vj = v; end
            if (m[i].busy && !m[i].rk && m_hit(m[i].qk, v)) begin nx[i].rk = 1'b1; nx[i].vk = v; end
        end
        if (d >= 0) begin
            m_op = m[d].op; m_rs1 = m[d].vj; m_rs2 = m[d].vk; m_robid = m[d].robid;
            nx[d].busy = 1'b0;
        end else begin
            m_op = '0;
        end
        if (iss_valid && f >= 0) begin
            nx[f].busy = 1'b1; nx[f].op = iss_op; nx[f].robid = iss_robid;
            nx[f].qj = iss_qj; nx[f].qk = iss_qk;
            nx[f].rj = !iss_qj_busy; nx[f].vj = iss_vj;
            nx[f].rk = !iss_qk_busy; nx[f].vk = iss_vk;
            if (iss_qj_busy && m_hit(iss_qj, v)) begin nx[f].rj = 1'b1; nx[f].vj = v; end
            if (iss_qk_busy && m_hit(iss_qk, v)) begin nx[f].rk = 1'b1; nx[f].vk = v; end
        end
        m = nx;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_op = '0; iss_vj = '0; iss_qj = '0; iss_qj_busy = 1'b0;
        iss_vk = '0; iss_qk = '0; iss_qk_busy = 1'b0; iss_robid = '0;
        alu_valid = 1'b0; alu_robid = '0; alu_result = '0;
        lsb_valid = 1'b0; lsb_robid = '0; lsb_result = '0;
        clear_in = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic qjb, input logic [3:0] qj,
                         input logic [31:0] vk, input logic qkb, input logic [3:0] qk, input logic [3:0] rob);
        iss_valid = 1'b1; iss_op = op; iss_vj = vj; iss_qj_busy = qjb; iss_qj = qj;
        iss_vk = vk; iss_qk_busy = qkb; iss_qk = qk; iss_robid = rob;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b0; idle();
        #2 rst_in = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if ({ex_op, ex_rs1, ex_rs2, ex_robid} !== '0) begin
            $display("FAIL reset_outputs: got op=%0d rs1=%h rs2=%h rob=%0d, want all 0", ex_op, ex_rs1, ex_rs2, ex_robid);
            n_fail++;
        end
        n_checks++;
        if (full !== 1'b0) begin $display("FAIL reset_full: got %b want 0", full); n_fail++; end
        @(posedge clk_in); @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1; rdy_in = 1'b1;
    endtask

    task automatic test_ready_issue();
        issue(OP_ADDI, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd4);
        tick(); idle();
        n_checks++;
        if (ex_op !== 6'd0) begin $display("FAIL addi_issue_edge: got op=%0d want 0", ex_op); n_fail++; end
        tick();
        n_checks++;
        if ({ex_op, ex_rs1, ex_rs2, ex_robid} !== {OP_ADDI, 32'd5, 32'd7, 4'd4}) begin
            $display("FAIL addi_dispatch: got op=%0d rs1=%0d rs2=%0d rob=%0d want %0d/5/7/4", ex_op, ex_rs1, ex_rs2, ex_robid, OP_ADDI);
            n_fail++;
        end
        tick();
        n_checks++;
        if (ex_op !== 6'd0) begin $display("FAIL addi_idle_after: got op=%0d want 0", ex_op); n_fail++; end
    endtask

    task automatic test_wakeup();
        issue(OP_ADD, 32'd0, 1'b1, 4'd3, 32'd1, 1'b0, 4'd0, 4'd5);
        tick(); idle(); tick();
        n_checks++;
        if (ex_op !== 6'd0) begin $display("FAIL wait_no_dispatch: got op=%0d want 0", ex_op); n_fail++; end
        alu_valid = 1'b1; alu_robid = 4'd3; alu_result = 32'h10;
        tick(); idle();
        n_checks++;
        if (ex_op !== 6'd0) begin $display("FAIL wakeup_edge: got op=%0d want 0", ex_op); n_fail++; end
        tick();
        n_checks++;
        if ({ex_op, ex_rs1, ex_rs2, ex_robid} !== {OP_ADD, 32'h10, 32'd1, 4'd5}) begin
            $display("FAIL wakeup_dispatch: got op=%0d rs1=%h rs2=%h rob=%0d want %0d/10/1/5", ex_op, ex_rs1, ex_rs2, ex_robid, OP_ADD);
            n_fail++;
        end
    endtask

    task automatic test_bypass();
        issue(OP_SUB, 32'h22, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 4'd6);
        lsb_valid = 1'b1; lsb_robid = 4'd2; lsb_result = 32'hAB;
        tick(); idle(); tick();
        n_checks++;
        if ({ex_op, ex_rs1, ex_rs2, ex_robid} !== {OP_SUB, 32'h22, 32'hAB, 4'd6}) begin
            $display("FAIL issue_bypass: got op=%0d rs1=%h rs2=%h rob=%0d want %0d/22/ab/6", ex_op, ex_rs1, ex_rs2, ex_robid, OP_SUB);
            n_fail++;
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < RS; i++) begin
            issue(OP_ADD, 32'd0, 1'b1, 4'd9, 32'(i), 1'b0, 4'd0, 4'(i));
            tick();
        end
        idle();
        n_checks++;
        if (full !== 1'b1) begin $display("FAIL full_after_fill: got %b want 1", full); n_fail++; end
        issue(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd15);
        tick(); idle();
        alu_valid = 1'b1; alu_robid = 4'd9; alu_result = 32'h99;
        tick(); idle();
        issue(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd14);
        tick(); idle();
        n_checks++;
        if ({ex_op, ex_rs1, ex_rs2, ex_robid} !== {OP_ADD, 32'h99, 32'd0, 4'd0}) begin
            $display("FAIL full_dispatch_0: got op=%0d rs1=%h rs2=%0d rob=%0d want %0d/99/0/0", ex_op, ex_rs1, ex_rs2, ex_robid, OP_ADD);
            n_fail++;
        end
        n_checks++;
        if (full !== 1'b0) begin $display("FAIL full_freed: got %b want 0", full); n_fail++; end
        for (int k = 1; k < RS; k++) begin
            tick();
            n_checks++;
            if ({ex_op, ex_rs1, ex_rs2, ex_robid} !== {OP_ADD, 32'h99, 32'(k), 4'(k)}) begin
                $display("FAIL full_dispatch_order: got op=%0d rs2=%0d rob=%0d want op=%0d rs2=%0d rob=%0d", ex_op, ex_rs2, ex_robid, OP_ADD, k, k);
                n_fail++;
            end
        end
        tick();
        n_checks++;
        if (ex_op !== 6'd0) begin $display("FAIL full_drained: got op=%0d rob=%0d want op 0", ex_op, ex_robid); n_fail++; end
    endtask

    task automatic test_clear();
        issue(OP_ADD, 32'd0, 1'b1, 4'd5, 32'd1, 1'b0, 4'd0, 4'd1); tick();
        issue(OP_ADD, 32'd0, 1'b1, 4'd5, 32'd2, 1'b0, 4'd0, 4'd2); tick();
        idle();
        alu_valid = 1'b1; alu_robid = 4'd5; alu_result = 32'h55;
        tick(); idle();
        clear_in = 1'b1;
        tick(); clear_in = 1'b0;
        n_checks++;
        if ({ex_op, full} !== {6'd0, 1'b0}) begin $display("FAIL clear_edge: got op=%0d full=%b want 0/0", ex_op, full); n_fail++; end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (ex_op !== 6'd0) begin $display("FAIL clear_nothing_after: got op=%0d rob=%0d want 0", ex_op, ex_robid); n_fail++; end
        end
    endtask

    task automatic test_rdy_low();
        issue(OP_ADDI, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd7);
        rdy_in = 1'b0;
        tick(); idle(); rdy_in = 1'b1;
        tick();
        n_checks++;
        if (ex_op !== 6'd0) begin $display("FAIL rdy_low_issue_dropped: got op=%0d want 0", ex_op); n_fail++; end
        issue(OP_ORI, 32'd0, 1'b1, 4'd6, 32'd8, 1'b0, 4'd0, 4'd8);
        tick(); idle();
        rdy_in = 1'b0; alu_valid = 1'b1; alu_robid = 4'd6; alu_result = 32'h66;
        tick(); idle(); rdy_in = 1'b1;
        tick(); tick();
        n_checks++;
        if (ex_op !== 6'd0) begin $display("FAIL rdy_low_bcast_lost: got op=%0d want 0", ex_op); n_fail++; end
        lsb_valid = 1'b1; lsb_robid = 4'd6; lsb_result = 32'h77;
        tick(); idle(); tick();
        n_checks++;
        if ({ex_op, ex_rs1, ex_rs2, ex_robid} !== {OP_ORI, 32'h77, 32'd8, 4'd8}) begin
            $display("FAIL rdy_resume_dispatch: got op=%0d rs1=%h rs2=%0d rob=%0d want %0d/77/8/8", ex_op, ex_rs1, ex_rs2, ex_robid, OP_ORI);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        issue(OP_ADDI, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd10); tick();
        issue(OP_ANDI, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd11); tick();
        idle();
        n_checks++;
        if ({ex_op, ex_robid} !== {OP_ADDI, 4'd10}) begin $display("FAIL pre_reset_dispatch: got op=%0d rob=%0d want %0d/10", ex_op, ex_robid, OP_ADDI); n_fail++; end
        #2 rst_in = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if ({ex_op, ex_rs1, ex_rs2, ex_robid, full} !== '0) begin
            $display("FAIL async_reset_outputs: got op=%0d rs1=%h rs2=%h rob=%0d full=%b want all 0", ex_op, ex_rs1, ex_rs2, ex_robid, full);
            n_fail++;
        end
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (ex_op !== 6'd0) begin $display("FAIL reset_discarded: got op=%0d rob=%0d want 0", ex_op, ex_robid); n_fail++; end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle();
            rdy_in   = ($urandom_range(0, 9) != 0);
            clear_in = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1)
                issue(6'($urandom_range(1, 63)), $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                      $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            alu_valid  = ($urandom_range(0, 9) < 4);
            alu_robid  = 4'($urandom_range(0, 7));
            alu_result = $urandom;
            lsb_valid  = ($urandom_range(0, 9) < 4);
            lsb_robid  = 4'($urandom_range(0, 7));
            lsb_result = $urandom;
            #1;
            n_checks++;
            if (full !== m_full()) begin $display("FAIL rand_full cycle %0d: got %b want %b", c, full, m_full()); n_fail++; end
            tick();
            n_checks++;
            if ({ex_op, ex_rs1, ex_rs2, ex_robid} !== {m_op, m_rs1, m_rs2, m_robid}) begin
                $display("FAIL rand_ex cycle %0d: got op=%0d rs1=%h rs2=%h rob=%0d want op=%0d rs1=%h rs2=%h rob=%0d",
                         c, ex_op, ex_rs1, ex_rs2, ex_robid, m_op, m_rs1, m_rs2, m_robid);
                n_fail++;
            end
        end
        idle(); rdy_in = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ready_issue();
        test_wakeup();
        test_bypass();
        test_full();
        test_clear();
        test_rdy_low();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station for integer/branch/jump ops; sits between decode/issue and the ALU.
- Holds issued ops until both operands are known.
- Snoops the ALU and LSB result broadcasts (CDB) to wake up waiting operands.
- Dispatches at most one ready op per cycle to the ALU as registered (rs1, rs2, op, robid).

Parameters:
RS_SIZE, 8, number of entries (power of two, >=2)
ROB_W, `RoB_addr, width of RoB tag
OP_W, 6, opcode width; op==0 means "no op"

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous reset, active-low
rdy_in  input  1  global ready; low freezes all state
clear_in  input  1  mispredict flush, synchronous
iss_valid  input  1  issue request this cycle
iss_op  input  OP_W  opcode (`const.v` encoding, nonzero)
iss_vj  input  32  operand 1 value (valid when !iss_qj_busy)
iss_qj  input  ROB_W  operand 1 producer tag
iss_qj_busy  input  1  operand 1 still pending
iss_vk  input  32  operand 2 value / immediate / pc
iss_qk  input  ROB_W  operand 2 producer tag
iss_qk_busy  input  1  operand 2 still pending
iss_robid  input  ROB_W  destination RoB tag
alu_valid  input  1  ALU broadcast valid
alu_robid  input  ROB_W  ALU broadcast tag
alu_result  input  32  ALU broadcast value
lsb_valid  input  1  LSB broadcast valid
lsb_robid  input  ROB_W  LSB broadcast tag
lsb_result  input  32  LSB broadcast value
full  output  1  no free entry; decoder must not issue
ex_rs1  output  32  operand 1 to ALU
ex_rs2  output  32  operand 2 to ALU
ex_op  output  OP_W  opcode to ALU; 0 = idle
ex_robid  output  ROB_W  tag to ALU

Behaviour:
- Entry state: busy, op, vj, vk, qj, qk, rj, rk (operand ready), robid.
- Reset (rst_in low, async): all busy=0; ex_rs1/ex_rs2/ex_op/ex_robid=0.
- rdy_in low: no entry changes; ex_op<=0 on each edge (the ALU fires on any nonzero op); broadcasts in this window are lost by contract.
- full: combinational; equals 1 iff all RS_SIZE entries are busy, based on the start-of-cycle state.
- Issue:
  - Issue is accepted iff iss_valid && !full && !clear_in.
  - The accepted op is written into the lowest-index free entry.
  - iss_valid while full is ignored. An entry freed by dispatch in the same cycle does not make room.
- Issue-time bypass: if iss_qj_busy and a valid broadcast (alu, then lsb) carries tag iss_qj this cycle, store rj=1 with the broadcast value. Same rule applies to qk.
- Wakeup: on each edge, every busy entry with !rj and qj==alu_robid&&alu_valid captures alu_result and sets rj. Same for lsb_*, and same for the k operand.
  - If both broadcasts match, alu wins (cannot occur legally).
- Dispatch:
  - Select the lowest-index busy entry with rj&&rk, using start-of-cycle state.
  - Next edge: ex_rs1=vj, ex_rs2=vk, ex_op=op, ex_robid=robid; entry busy<=0.
  - With no candidate: ex_op<=0; other ex_* hold.
- Latency:
  - An issued op with both operands ready dispatches on the edge after the issue edge, so ex_op is visible 1 cycle after issue.
  - An operand woken at edge N makes the entry eligible at edge N+1.
- Simultaneous issue and dispatch in the same cycle are allowed and use different entries.
- clear_in (priority over issue and dispatch): all busy<=0, ex_op<=0.
- Reset mid-operation discards everything immediately.
- Tags are opaque; ROB wrap-around is handled by RoB uniqueness of in-flight tags.

Decomposition:
- const.v (shared): opcode defines (`Lui..`Sub), `RoB_addr, RS_SIZE default.
- Sub-module rs_pick: parameterised lowest-index priority encoder (vector in -> index + found). Instantiated twice: free-slot select and ready select.

Test Plan:
- Issue Addi, vj=5, vk=7, both ready -> next cycle ex_op=`Addi, ex_rs1=5, ex_rs2=7, ex_robid=iss_robid; following cycle ex_op=0.
- Issue Add, qj=3 busy, vk=1 -> ex_op stays 0. Then alu_valid, alu_robid=3, alu_result=0x10 -> ex_op=`Add, ex_rs1=0x10 one cycle after wakeup.
- Issue with qk=2 busy in the same cycle as lsb_valid, lsb_robid=2, lsb_result=0xAB -> dispatches next cycle with ex_rs2=0xAB.
- Fill 8 entries all waiting on tag 9 -> full=1; a 9th iss_valid is ignored. Broadcast tag 9 -> entries dispatch in index order 0..7, one per cycle.
- Two ready entries plus clear_in -> ex_op=0 next cycle, full=0, nothing dispatches afterward.
- Assert rst_in low mid-stream with entries busy -> outputs 0 immediately without a clock edge; after release, ex_op=0.
